inst_pre_stream: RTL and testbench
==================================

# inst_pre_stream

Next-generation instruction prefetcher between the fetch stage and the L2 cache. It learns per-PC next-line behaviour (sequential vs. jump target) in a tagged, hashed table and turns each new fetch line into a burst of up to DEGREE prefetch requests. Requests are buffered in a small queue and drained through a valid/ready handshake. L2 feedback (anneal) adjusts a per-entry confidence counter that gates issue.

## Interface
- ADDR_WIDTH, 32, line-address width; "next line" is address + 1.
- HASH_WIDTH, 10, table index width; the table has 2^HASH_WIDTH entries.
- TAG_WIDTH, 8, partial tag taken from address bits [HASH_WIDTH +: TAG_WIDTH].
- DEGREE, 2, maximum prefetches per trigger; range 1..8.
- QDEPTH, 4, request queue depth; power of 2, at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset. Asynchronous, active-high.
- fetch_valid  in  1  fetch line address is valid this cycle.
- fetch_addr  in  ADDR_WIDTH  fetch line address.
- flush  in  1  pipeline redirect.
- pf_valid  out  1  queue head holds a request.
- pf_addr  out  ADDR_WIDTH  line address at the queue head.
- pf_ready  in  1  L2 accepts the head request.
- anneal_valid  in  1  L2 feedback on an instruction prefetch.
- anneal_addr  in  ADDR_WIDTH  trigger PC line of the prefetch being reported.
- anneal_good  in  1  1 = prefetched line was used; 0 = evicted unused.

## Operation
- Trigger: the cycle has fetch_valid=1, and either fetch_addr differs from the registered last address P or P is invalid.
- Table entry fields: valid, tag, target, taken[1:0], conf[1:0].
  - Valid bits reset to 0.
  - Data fields are not reset.
- Lookup is combinational on trigger address A, using hash = A[HASH_WIDTH-1:0].
  - Hit means valid and tag match.
- First prefetch address T:
  - Hit with conf[1]=1: T = taken[1] ? target : A+1.
  - Miss: T = A+1.
  - Hit with conf[1]=0: no burst; A is only recorded as P.
- Training happens on a trigger when P is valid.
  - jump = (A != P+1).
  - Entry hash(P), on a miss: allocate with valid=1, tag, target=A, taken = jump ? 2'b10 : 2'b01, conf=2'b10.
  - Entry hash(P), on a hit: taken saturates up on a jump and down otherwise; target is overwritten with A on a jump only.
- Anneal: entry hash(anneal_addr), on a hit only.
  - conf saturates up when anneal_good=1, down when anneal_good=0.
  - A miss is ignored.
- Same index written by training and anneal in one cycle:
  - If training allocates, conf=2'b10 and the anneal is dropped.
  - Otherwise training writes taken/target and anneal writes conf.
- Generator FSM:
  - IDLE: on a trigger with a burst, load base=T and cnt=0, then go to ISSUE.
  - ISSUE: push base+cnt when the queue is not full, then cnt++. After pushing cnt = DEGREE-1, return to IDLE. When the queue is full, hold.
  - A new trigger in ISSUE restarts the burst with the new T; remaining addresses of the old burst are discarded.
- Duplicate suppression: a push equal to the most recently pushed address is skipped, but cnt still advances.
- Address arithmetic wraps modulo 2^ADDR_WIDTH. All-ones + 1 = 0.
- Queue is a FIFO. Push and pop in the same cycle are allowed when full (occupancy unchanged).
- flush, synchronous, takes priority over everything:
  - Queue emptied, FSM to IDLE, P invalidated.
  - Table kept; no training and no trigger that cycle.

## Timing
- Reset values: pf_valid=0, pf_addr=0, queue empty, FSM IDLE, P invalid, all table valid bits 0.
- A trigger in cycle t produces the first push at the end of t+1; pf_valid=1 in t+2.
- Steady rate is one push per cycle while not full, so a DEGREE-burst is fully queued by the end of t+DEGREE.
- Handshake:
  - pf_addr is stable while pf_valid=1 and pf_ready=0.
  - Pop occurs on pf_valid & pf_ready.
- A training write in cycle t is visible to lookups from t+1. There is no same-cycle forwarding.
- rst asserted mid-burst clears everything immediately; the first post-reset trigger does not train.

## Structure
- Package inst_pre_pkg holds:
  - The entry struct (valid, tag, target, taken, conf).
  - FSM state enum (IDLE, ISSUE).
  - Counter constants: CONF_INIT=2'b10, TAKEN_JUMP_INIT=2'b10, TAKEN_SEQ_INIT=2'b01.
- Sub-module pre_queue: parametrised FIFO (ADDR_WIDTH, QDEPTH) with push/full/pop/empty and a synchronous clear.
- The existing transformer_2bit is reused for the taken and conf saturating counters.

## Test plan
- Reset, then fetch 0x100: pf_addr 0x101 in cycle t+2, then 0x102 in t+3 (DEGREE=2, pf_ready=1).
- Fetch 0x200 → 0x300 → 0x200 → 0x300: second visit of 0x200 prefetches 0x300 and 0x301 (taken=2'b10 hit).
- Entry for 0x200 plus two anneal_good=0 reports: conf drops to 2'b00; next fetch of 0x200 issues nothing.
- pf_ready=0 with QDEPTH=4, DEGREE=2: triggers 0x10, 0x20, 0x30 fill the queue with 0x11, 0x12, 0x21, 0x22; FSM holds on 0x31 until one pop.
- Fetch 0x400 and, one cycle later, 0x500 while the burst is active: 0x402 is never issued; 0x501 follows.
- fetch_addr = all-ones with DEGREE=2: pushes 0x0 then 0x1. flush mid-burst gives pf_valid=0 the next cycle.

Source files
------------

// File: rtl/inst_pre_stream_pkg.sv
// inst_pre_pkg: shared types and constants for the instruction prefetcher.
//   entry_t     - prediction table entry (valid, tag, target, taken, conf).
//                 Fields are sized for the widest supported configuration
//                 (32-bit line addresses, 8-bit tags). Narrower instances
//                 zero-extend on write and truncate on read.
//   gen_state_t - burst generator state.
//   CONF_INIT / TAKEN_JUMP_INIT / TAKEN_SEQ_INIT - counter values on allocation.
package inst_pre_pkg;

  localparam int unsigned ENTRY_ADDR_W = 32;
  localparam int unsigned ENTRY_TAG_W  = 8;

  typedef struct packed {
    logic                    valid;
    logic [ENTRY_TAG_W-1:0]  tag;
    logic [ENTRY_ADDR_W-1:0] target;
    logic [1:0]              taken;
    logic [1:0]              conf;
  } entry_t;

  typedef enum logic {
    IDLE,
    ISSUE
  } gen_state_t;

  localparam logic [1:0] CONF_INIT       = 2'b10;
  localparam logic [1:0] TAKEN_JUMP_INIT = 2'b10;
  localparam logic [1:0] TAKEN_SEQ_INIT  = 2'b01;

endpackage

// File: rtl/inst_pre_stream_queue.sv
// pre_queue: prefetch request FIFO.
//   clk, rst    - clock, asynchronous active-high reset
//   clear       - synchronous empty (pipeline flush)
//   push        - enqueue push_data; accepted when not full, or when full
//                 and a pop happens in the same cycle
//   full, empty - occupancy flags
//   pop         - dequeue head (ignored when empty)
//   head_data   - head entry, 0 when empty
module pre_queue #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned QDEPTH     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  push,
  input  logic [ADDR_WIDTH-1:0] push_data,
  output logic                  full,
  input  logic                  pop,
  output logic                  empty,
  output logic [ADDR_WIDTH-1:0] head_data
);

  localparam int unsigned PW = $clog2(QDEPTH);

  logic [ADDR_WIDTH-1:0] mem [QDEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [PW:0]           count;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(QDEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= push_data;
  end

  assign head_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/transformer_2bit.sv
// transformer_2bit: next value of a 2-bit saturating counter.
//   cur - current counter value
//   inc - 1 = count up (saturate at 3), 0 = count down (saturate at 0)
//   nxt - updated counter value
module transformer_2bit (
  input  logic [1:0] cur,
  input  logic       inc,
  output logic [1:0] nxt
);

  always_comb begin
    nxt = cur;
    if (inc) begin
      if (cur != 2'b11) nxt = cur + 2'b01;
    end else begin
      if (cur != 2'b00) nxt = cur - 2'b01;
    end
  end

endmodule

// File: rtl/inst_pre_stream.sv
// inst_pre_stream: instruction prefetcher between fetch and L2.
// Learns per-PC next-line behaviour in a tagged table, turns each new fetch
// line into a burst of up to DEGREE line prefetches, queues them, and drains
// them over a valid/ready handshake. L2 anneal feedback tunes confidence.
//   clk, rst                   - clock, asynchronous active-high reset
//   fetch_valid, fetch_addr    - fetched line address
//   flush                      - pipeline redirect: drop queue, burst, last PC
//   pf_valid, pf_addr          - queue head request
//   pf_ready                   - L2 accepts the head request
//   anneal_valid, anneal_addr, - L2 feedback for the trigger PC line;
//   anneal_good                  good=1 raises confidence, 0 lowers it
module inst_pre_stream
  import inst_pre_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned HASH_WIDTH = 10,
  parameter int unsigned TAG_WIDTH  = 8,
  parameter int unsigned DEGREE     = 2,
  parameter int unsigned QDEPTH     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_valid,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  input  logic                  flush,
  output logic                  pf_valid,
  output logic [ADDR_WIDTH-1:0] pf_addr,
  input  logic                  pf_ready,
  input  logic                  anneal_valid,
  input  logic [ADDR_WIDTH-1:0] anneal_addr,
  input  logic                  anneal_good
);

  localparam int unsigned         ENTRIES  = 1 << HASH_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ONE    = ADDR_WIDTH'(1);
  localparam logic [2:0]          LAST_CNT = 3'(DEGREE - 1);

  function automatic logic [HASH_WIDTH-1:0] hash_of(input logic [ADDR_WIDTH-1:0] a);
    return a[HASH_WIDTH-1:0];
  endfunction

  function automatic logic [ENTRY_TAG_W-1:0] tag_of(input logic [ADDR_WIDTH-1:0] a);
    return ENTRY_TAG_W'(a[HASH_WIDTH +: TAG_WIDTH]);
  endfunction

  // ---------------- last fetch address / trigger ----------------
  logic [ADDR_WIDTH-1:0] p_addr;
  logic                  p_valid;
  logic                  trigger;
  logic                  train;

  assign trigger = fetch_valid & ~flush & (~p_valid | (fetch_addr != p_addr));
  assign train   = trigger & p_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_addr  <= '0;
      p_valid <= 1'b0;
    end else if (flush) begin
      p_valid <= 1'b0;
    end else if (trigger) begin
      p_addr  <= fetch_addr;
      p_valid <= 1'b1;
    end
  end

  // ---------------- prediction table ----------------
  // Valid bits live in their own resettable vector so the data array
  // needs no reset.
  logic [ENTRIES-1:0] vbits;
  entry_t             tbl [ENTRIES];

  logic [HASH_WIDTH-1:0] a_idx, p_idx, n_idx;
  logic                  a_hit, p_hit, n_hit;
  logic [ADDR_WIDTH-1:0] a_target;
  logic                  jump;
  logic                  burst;
  logic [ADDR_WIDTH-1:0] first_t;
  logic [1:0]            taken_nxt, conf_nxt;
  logic                  train_alloc, anneal_wr;
  logic                  unused_anneal_hi;

  assign unused_anneal_hi = ^anneal_addr;

  assign a_idx    = hash_of(fetch_addr);
  assign p_idx    = hash_of(p_addr);
  assign n_idx    = hash_of(anneal_addr);
  assign a_hit    = vbits[a_idx] & (tbl[a_idx].tag == tag_of(fetch_addr));
  assign p_hit    = vbits[p_idx] & (tbl[p_idx].tag == tag_of(p_addr));
  assign n_hit    = anneal_valid & vbits[n_idx] & (tbl[n_idx].tag == tag_of(anneal_addr));
  assign a_target = tbl[a_idx].target[ADDR_WIDTH-1:0];

  // A confident hit follows the learned direction; a miss guesses sequential.
  assign burst   = trigger & (~a_hit | tbl[a_idx].conf[1]);
  assign first_t = (a_hit & tbl[a_idx].taken[1]) ? a_target : fetch_addr + ONE;

  assign jump        = (fetch_addr != p_addr + ONE);
  assign train_alloc = train & ~p_hit;
  // An allocation owns the whole entry, so a same-index anneal is dropped.
  assign anneal_wr   = n_hit & ~(train_alloc & (n_idx == p_idx));

  transformer_2bit u_taken_ctr (
    .cur (tbl[p_idx].taken),
    .inc (jump),
    .nxt (taken_nxt)
  );

  transformer_2bit u_conf_ctr (
    .cur (tbl[n_idx].conf),
    .inc (anneal_good),
    .nxt (conf_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vbits <= '0;
    end else if (train_alloc) begin
      vbits[p_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (anneal_wr) tbl[n_idx].conf <= conf_nxt;
    if (train) begin
      if (!p_hit) begin
        tbl[p_idx].valid  <= 1'b1;
        tbl[p_idx].tag    <= tag_of(p_addr);
        tbl[p_idx].target <= ENTRY_ADDR_W'(fetch_addr);
        tbl[p_idx].taken  <= jump ? TAKEN_JUMP_INIT : TAKEN_SEQ_INIT;
        tbl[p_idx].conf   <= CONF_INIT;
      end else begin
        tbl[p_idx].taken <= taken_nxt;
        if (jump) tbl[p_idx].target <= ENTRY_ADDR_W'(fetch_addr);
      end
    end
  end

  // ---------------- burst generator ----------------
  gen_state_t            state, state_nxt;
  logic [ADDR_WIDTH-1:0] base;
  logic [2:0]            cnt;
  logic [ADDR_WIDTH-1:0] lp_addr;
  logic                  lp_valid;
  logic [ADDR_WIDTH-1:0] cand;
  logic                  advance, dup, q_push;
  logic                  q_full, q_empty, pop_fire;

  assign pf_valid = ~q_empty;
  assign pop_fire = pf_valid & pf_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // A burst trigger wins over finishing the current burst, so a restart
  // in ISSUE keeps the generator busy with the new base.
  always_comb begin
    state_nxt = state;
    if (flush)                                             state_nxt = IDLE;
    else if (burst)                                        state_nxt = ISSUE;
    else if (state == ISSUE && advance && cnt == LAST_CNT) state_nxt = IDLE;
  end

  // The queue accepts a push while full if the head is popped that cycle.
  always_comb begin
    cand    = base + ADDR_WIDTH'(cnt);
    advance = 1'b0;
    dup     = 1'b0;
    q_push  = 1'b0;
    if (state == ISSUE && !flush && (!q_full || pop_fire)) begin
      advance = 1'b1;
      dup     = lp_valid & (cand == lp_addr);
      q_push  = ~dup;
    end
  end

  // The old burst's push in a restart cycle still happens; only the
  // addresses after it are discarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base     <= '0;
      cnt      <= '0;
      lp_addr  <= '0;
      lp_valid <= 1'b0;
    end else if (flush) begin
      cnt      <= '0;
      lp_valid <= 1'b0;
    end else begin
      if (burst) begin
        base <= first_t;
        cnt  <= '0;
      end else if (advance) begin
        cnt <= cnt + 3'd1;
      end
      if (q_push) begin
        lp_addr  <= cand;
        lp_valid <= 1'b1;
      end
    end
  end

  pre_queue #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .QDEPTH     (QDEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .push      (q_push),
    .push_data (cand),
    .full      (q_full),
    .pop       (pf_ready),
    .empty     (q_empty),
    .head_data (pf_addr)
  );

endmodule

// File: tb/tb_inst_pre_stream.sv
module tb_inst_pre_stream;

  localparam int unsigned AW     = 32;
  localparam int unsigned HW     = 10;
  localparam int unsigned TW     = 8;
  localparam int unsigned DEGREE = 2;
  localparam int unsigned QDEPTH = 4;
  localparam int unsigned NENT   = 1 << HW;

  logic          clk = 1'b0;
  logic          rst;
  logic          fetch_valid;
  logic [AW-1:0] fetch_addr;
  logic          flush;
  logic          pf_valid;
  logic [AW-1:0] pf_addr;
  logic          pf_ready;
  logic          anneal_valid;
  logic [AW-1:0] anneal_addr;
  logic          anneal_good;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  inst_pre_stream #(
    .ADDR_WIDTH (AW),
    .HASH_WIDTH (HW),
    .TAG_WIDTH  (TW),
    .DEGREE     (DEGREE),
    .QDEPTH     (QDEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .fetch_valid  (fetch_valid),
    .fetch_addr   (fetch_addr),
    .flush        (flush),
    .pf_valid     (pf_valid),
    .pf_addr      (pf_addr),
    .pf_ready     (pf_ready),
    .anneal_valid (anneal_valid),
    .anneal_addr  (anneal_addr),
    .anneal_good  (anneal_good)
  );

  // ---------------- reference model ----------------
  logic [AW-1:0] sb [$];       // expected queue contents (scoreboard)
  logic [AW-1:0] pending [$];  // burst addresses still to be pushed
  logic [AW-1:0] m_paddr, m_lp;
  bit            m_pvalid, m_lpvalid;
  bit            mv      [NENT];
  logic [TW-1:0] mtag    [NENT];
  logic [AW-1:0] mtarget [NENT];
  int            mtaken  [NENT];
  int            mconf   [NENT];

  task automatic check(input string nm, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    pending.delete();
    m_pvalid  = 0;
    m_lpvalid = 0;
    for (int i = 0; i < NENT; i++) mv[i] = 0;
  endtask

  function automatic int unsigned idx_of(input logic [AW-1:0] a);
    return int'(a[HW-1:0]);
  endfunction

  function automatic bit hit_of(input logic [AW-1:0] a);
    return mv[idx_of(a)] && (mtag[idx_of(a)] == a[HW +: TW]);
  endfunction

  // One clock edge of behaviour, evaluated on the state before the edge.
  task automatic model_step();
    int unsigned ia, ip, in_;
    bit          trig, ann_hit, alloc, jump;
    int          ann_conf;
    logic [AW-1:0] t, a;

    in_      = idx_of(anneal_addr);
    ann_hit  = anneal_valid && hit_of(anneal_addr);
    ann_conf = anneal_good ? ((mconf[in_] < 3) ? mconf[in_] + 1 : 3)
                           : ((mconf[in_] > 0) ? mconf[in_] - 1 : 0);
    alloc    = 0;
    ip       = idx_of(m_paddr);

    if (flush) begin
      sb.delete();
      pending.delete();
      m_pvalid  = 0;
      m_lpvalid = 0;
    end else begin
      if (pending.size() > 0 && sb.size() < QDEPTH) begin
        a = pending.pop_front();
        if (!(m_lpvalid && a == m_lp)) begin
          sb.push_back(a);
          m_lp      = a;
          m_lpvalid = 1;
        end
      end
      trig = fetch_valid && (!m_pvalid || fetch_addr != m_paddr);
      if (trig) begin
        ia = idx_of(fetch_addr);
        if (!hit_of(fetch_addr) || mconf[ia] >= 2) begin
          t = (hit_of(fetch_addr) && mtaken[ia] >= 2) ? mtarget[ia] : fetch_addr + 1;
          pending.delete();
          for (int d = 0; d < DEGREE; d++) pending.push_back(t + AW'(d));
        end
        if (m_pvalid) begin
          jump = (fetch_addr != m_paddr + 1);
          if (!hit_of(m_paddr)) begin
            alloc        = 1;
            mv[ip]       = 1;
            mtag[ip]     = m_paddr[HW +: TW];
            mtarget[ip]  = fetch_addr;
            mtaken[ip]   = jump ? 2 : 1;
            mconf[ip]    = 2;
          end else begin
            mtaken[ip] = jump ? ((mtaken[ip] < 3) ? mtaken[ip] + 1 : 3)
                              : ((mtaken[ip] > 0) ? mtaken[ip] - 1 : 0);
            if (jump) mtarget[ip] = fetch_addr;
          end
        end
        m_paddr  = fetch_addr;
        m_pvalid = 1;
      end
    end
    if (ann_hit && !(alloc && in_ == ip)) mconf[in_] = ann_conf;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      check("pf_valid", {31'd0, pf_valid}, {31'd0, sb.size() > 0});
      if (sb.size() > 0) begin
        check("pf_addr", pf_addr, sb[0]);
        if (pf_ready) void'(sb.pop_front());
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    if (!rst) model_step();
    #1;
  endtask

  task automatic quiet();
    fetch_valid  = 0;
    flush        = 0;
    anneal_valid = 0;
  endtask

  task automatic fetch(input logic [AW-1:0] a);
    quiet();
    fetch_valid = 1;
    fetch_addr  = a;
    step();
    quiet();
  endtask

  task automatic idle(input int unsigned n);
    quiet();
    repeat (n) step();
  endtask

  task automatic anneal(input logic [AW-1:0] a, input bit g);
    quiet();
    anneal_valid = 1;
    anneal_addr  = a;
    anneal_good  = g;
    step();
    quiet();
  endtask

  task automatic do_flush();
    quiet();
    flush = 1;
    step();
    quiet();
  endtask

  task automatic do_reset();
    quiet();
    rst = 1;
    model_reset();
    step();
    step();
    rst = 0;
    @(negedge clk);
    check("reset_pf_valid", {31'd0, pf_valid}, '0);
    check("reset_pf_addr", pf_addr, '0);
    #1;
  endtask

  logic [AW-1:0] pool [10];

  initial begin
    pool = '{32'h0000_0200, 32'h0000_0300, 32'h0000_0201, 32'h0000_0301,
             32'h0000_0600, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0100,
             32'h0000_0101, 32'h0000_0700};
    rst = 1; pf_ready = 1; fetch_addr = '0; anneal_addr = '0; anneal_good = 0;
    quiet();
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("reset_pf_valid", {31'd0, pf_valid}, '0);
    check("reset_pf_addr", pf_addr, '0);
    #1;

    // Basic burst after reset.
    pf_ready = 1;
    fetch(32'h100);
    idle(4);

    // Learn a jump 0x200 -> 0x300 and replay it.
    fetch(32'h200); idle(3);
    fetch(32'h300); idle(3);
    fetch(32'h200); idle(3);
    fetch(32'h300); idle(3);

    // Two bad anneals silence the 0x200 entry.
    anneal(32'h200, 0);
    anneal(32'h200, 0);
    fetch(32'h200); idle(3);
    fetch(32'h300); idle(3);

    // Queue fill with L2 stalled.
    pf_ready = 0;
    fetch(32'h10); idle(3);
    fetch(32'h20); idle(3);
    fetch(32'h30); idle(4);
    pf_ready = 1;
    idle(8);

    // Restart mid-burst.
    pf_ready = 0;
    fetch(32'h400);
    fetch(32'h500);
    idle(4);
    pf_ready = 1;
    idle(6);

    // Address wrap, then flush mid-burst.
    fetch(32'hFFFF_FFFF); idle(4);
    pf_ready = 0;
    fetch(32'h800);
    idle(2);
    do_flush();
    idle(2);
    pf_ready = 1;

    // Reset mid-burst; first trigger afterwards does not train.
    pf_ready = 0;
    fetch(32'h900);
    idle(1);
    do_reset();
    pf_ready = 1;
    fetch(32'h900); fetch(32'h950); idle(4);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) do_reset();
      quiet();
      pf_ready = ($urandom_range(99) < 70);
      if ($urandom_range(99) < 3) begin
        flush = 1;
      end else begin
        fetch_valid = ($urandom_range(99) < 50);
        fetch_addr  = ($urandom_range(99) < 10) ? $urandom() : pool[$urandom_range(9)];
        if ($urandom_range(99) < 20) begin
          anneal_valid = 1;
          anneal_addr  = pool[$urandom_range(9)];
          anneal_good  = ($urandom_range(99) < 60);
        end
      end
      step();
    end

    quiet();
    pf_ready = 1;
    idle(10);
    check("drained", sb.size(), '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
